// File: rtl/fifo_flags.sv
// Single-clock synchronous FIFO with occupancy count, almost-full/almost-empty and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise dataOut is registered (1-cycle latency).
module fifo_flags #(
    parameter int DWIDTH    = 8,
    parameter int AWIDTH    = 3,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr,
    input  logic              rd,
    input  logic              clrErr,
    input  logic [DWIDTH-1:0] dataIn,
    output logic [DWIDTH-1:0] dataOut,
    output logic              empty,
    output logic              full,
    output logic              almostEmpty,
    output logic              almostFull,
    output logic [AWIDTH:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0] AF_C    = (AWIDTH+1)'(AF_THRESH);
    localparam logic [AWIDTH:0] AE_C    = (AWIDTH+1)'(AE_THRESH);
    localparam logic [AWIDTH:0] ONE_C   = (AWIDTH+1)'(1'b1);
    localparam logic [AWIDTH:0] ZERO_C  = (AWIDTH+1)'(1'b0);

    logic [DWIDTH-1:0] mem_q [DEPTH];

    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [AWIDTH:0]   count_q,  count_d;
    logic              empty_q,  empty_d;
    logic              full_q,   full_d;
    logic              ae_q,     ae_d;
    logic              af_q,     af_d;
    logic              ovf_q,    ovf_d;
    logic              udf_q,    udf_d;
    logic              wr_acc_s, rd_acc_s;

    // Accept decisions and next state; with en=0 every _d equals its _q.
    always_comb begin
        rd_acc_s = en & rd & ~empty_q;
        // A read in the same cycle frees a slot, so a full FIFO can still take the write.
        wr_acc_s = en & wr & (~full_q | rd_acc_s);

        wr_ptr_d = wr_acc_s ? (wr_ptr_q + AWIDTH'(1'b1)) : wr_ptr_q;
        rd_ptr_d = rd_acc_s ? (rd_ptr_q + AWIDTH'(1'b1)) : rd_ptr_q;

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase

        empty_d = (count_d == ZERO_C);
        full_d  = (count_d == DEPTH_C);
        ae_d    = (count_d <= AE_C);
        af_d    = (count_d >= AF_C);

        // New error events win over a coincident clear.
        ovf_d = en ? ((ovf_q & ~clrErr) | (wr & ~wr_acc_s)) : ovf_q;
        udf_d = en ? ((udf_q & ~clrErr) | (rd & empty_q))   : udf_q;
    end

    // Pointer, count and flag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= {AWIDTH{1'b0}};
            rd_ptr_q <= {AWIDTH{1'b0}};
            count_q  <= ZERO_C;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ae_q     <= 1'b1;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ae_q     <= ae_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (rst && wr_acc_s) begin
            mem_q[wr_ptr_q] <= dataIn;
        end
    end

`ifdef FIFO_FWFT_EN
    assign dataOut = mem_q[rd_ptr_q];
`else
    logic [DWIDTH-1:0] data_q;

    // Registered read port: loads the head word on the edge that accepts a read.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q <= {DWIDTH{1'b0}};
        end else if (rd_acc_s) begin
            data_q <= mem_q[rd_ptr_q];
        end
    end

    assign dataOut = data_q;
`endif

    assign empty       = empty_q;
    assign full        = full_q;
    assign almostEmpty = ae_q;
    assign almostFull  = af_q;
    assign count       = count_q;
    assign overflow    = ovf_q;
    assign underflow   = udf_q;

endmodule

// File: tb/tb_fifo_flags.sv
// Bench for fifo_flags: directed scenarios then random traffic, checked against a queue-based model.
module tb_fifo_flags;

    logic       clk = 1'b0;
    logic       rst, en, wr, rd, clrErr;
    logic [7:0] dataIn;
    logic [7:0] dataOut;
    logic       empty, full, almostEmpty, almostFull, overflow, underflow;
    logic [3:0] count;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq[$];
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;
    logic [7:0] m_dout = 8'h00;

    fifo_flags #(.DWIDTH(8), .AWIDTH(3), .AF_THRESH(6), .AE_THRESH(1)) dut (
        .clk(clk), .rst(rst), .en(en), .wr(wr), .rd(rd), .clrErr(clrErr),
        .dataIn(dataIn), .dataOut(dataOut), .empty(empty), .full(full),
        .almostEmpty(almostEmpty), .almostFull(almostFull), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = mq.size();
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ".full"}, 32'(full), 32'(n == 8));
        chk({tag, ".aempty"}, 32'(almostEmpty), 32'(n <= 1));
        chk({tag, ".afull"}, 32'(almostFull), 32'(n >= 6));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".udf"}, 32'(underflow), 32'(m_udf));
`ifdef FIFO_FWFT_EN
        if (n > 0) chk({tag, ".dout"}, 32'(dataOut), 32'(mq[0]));
`else
        chk({tag, ".dout"}, 32'(dataOut), 32'(m_dout));
`endif
    endtask

    // One clock: drive at negedge, update the model at posedge, check at the next negedge.
    task automatic cycle(input string tag, input logic r, input logic e, input logic w,
                         input logic rr, input logic c, input logic [7:0] d);
        int  n;
        bit  do_rd, do_wr;
        rst = r; en = e; wr = w; rd = rr; clrErr = c; dataIn = d;
        @(posedge clk);
        n = mq.size();
        if (!r) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_dout = 8'h00;
        end else if (e) begin
            do_rd = rr && (n > 0);
            do_wr = w && ((n < 8) || do_rd);
            m_ovf = (m_ovf && !c) || (w && !do_wr);
            m_udf = (m_udf && !c) || (rr && n == 0);
            if (do_rd) m_dout = mq.pop_front();
            if (do_wr) mq.push_back(d);
        end
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; wr = 1'b0; rd = 1'b0; clrErr = 1'b0; dataIn = 8'h00;
        @(negedge clk);
        cycle("reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("reset.count_lit", 32'(count), 32'd0);
        chk("reset.empty_lit", 32'(empty), 32'd1);
        chk("reset.ae_lit", 32'(almostEmpty), 32'd1);

        // 1: fill with 0..7
        for (int i = 0; i < 8; i++) cycle("t1.fill", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'(i));
        chk("t1.full_lit", 32'(full), 32'd1);
        chk("t1.af_lit", 32'(almostFull), 32'd1);

        // 2: overflow, clear, data not corrupted
        cycle("t2.ovf", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hAA);
        chk("t2.ovf_lit", 32'(overflow), 32'd1);
        chk("t2.count_lit", 32'(count), 32'd8);
        cycle("t2.clr", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("t2.clr_lit", 32'(overflow), 32'd0);
        cycle("t2.rd0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
`ifndef FIFO_FWFT_EN
        chk("t2.rd0_lit", 32'(dataOut), 32'd0);
`endif
        cycle("t2.refill", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd7);

        // 3: simultaneous rd/wr while full, then drain
        cycle("t3.rw_full", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd8);
        chk("t3.count_lit", 32'(count), 32'd8);
        chk("t3.ovf_lit", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) cycle("t3.drain", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
`ifndef FIFO_FWFT_EN
        chk("t3.last_lit", 32'(dataOut), 32'd8);
`endif

        // 4: simultaneous rd/wr while empty, then pointer wrap
        cycle("t4.rw_empty", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h55);
        chk("t4.udf_lit", 32'(underflow), 32'd1);
        chk("t4.count_lit", 32'(count), 32'd1);
        cycle("t4.rd55", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 20; i++) begin
            cycle("t4.wr", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h30 + i));
            cycle("t4.rd", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        end

        // 5: en=0 freezes everything
        cycle("t5.pre", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h11);
        cycle("t5.pre", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h22);
        for (int i = 0; i < 3; i++) cycle("t5.frozen", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hEE);

        // 6: reset mid-stream
        for (int i = 0; i < 3; i++) cycle("t6.wr", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
        cycle("t6.rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("t6.count_lit", 32'(count), 32'd0);
        cycle("t6.wr9", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd9);
        cycle("t6.rd9", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle("rand",
                  ($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 9) != 0),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 19) == 0),
                  8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
